// File: rtl/pipeline_tail_fifo.sv
// Elastic valid/ready output stage behind a fixed-latency pipeline; also drives the pipeline-advance enable.
// Define PIPE_TAIL_REGISTERED_READY_EN to drive pipe_ready from registered occupancy only (no nready path).
module pipeline_tail_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pvalid,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    pipe_ready,
  output logic                    valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    nready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign valid = !empty;

`ifdef PIPE_TAIL_REGISTERED_READY_EN
  assign pipe_ready = !full;
`else
  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign pipe_ready = !full || nready;
`endif

  assign push = pvalid && pipe_ready;
  assign pop  = valid && nready;

  // Control state: pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: tb/tb_pipeline_tail_fifo.sv
// Randomized self-checking bench for pipeline_tail_fifo against a queue-based reference model.
module tb_pipeline_tail_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pvalid;
  logic [DW-1:0] data_in;
  logic          pipe_ready;
  logic          valid;
  logic [DW-1:0] data_out;
  logic          nready;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];

  pipeline_tail_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pvalid(pvalid), .data_in(data_in),
    .pipe_ready(pipe_ready), .valid(valid), .data_out(data_out),
    .nready(nready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic nr);
`ifdef PIPE_TAIL_REGISTERED_READY_EN
    return q.size() < DEPTH;
`else
    return (q.size() < DEPTH) || nr;
`endif
  endfunction

  // One cycle: drive at negedge, compare against model, apply edge to model.
  task automatic step(input logic pv, input logic [DW-1:0] d, input logic nr, output logic acc);
    logic popd;
    pvalid = pv; data_in = d; nready = nr;
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("valid", 64'(valid), 64'(q.size() > 0));
    chk("pipe_ready", 64'(pipe_ready), 64'(model_ready(nr)));
    if (q.size() > 0) chk("data_out", 64'(data_out), 64'(q[0]));
    acc  = pv && model_ready(nr);
    popd = (q.size() > 0) && nr;
    @(posedge clk);
    if (popd) void'(q.pop_front());
    if (acc) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic drive(input logic pv, input logic [DW-1:0] d, input logic nr);
    pvalid = pv; data_in = d; nready = nr;
    #1;
  endtask

  initial begin
    logic acc;
    logic [DW-1:0] tok;
    int accepted;
    int cycles;

    rst = 1'b0; pvalid = 1'b0; data_in = '0; nready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_pipe_ready", 64'(pipe_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Streaming 1..100 with downstream always ready
    for (int i = 1; i <= 100; i++) begin
      if (i >= 2) begin
        drive(1'b1, DW'(i), 1'b1);
        chk("stream_count_lit", 64'(count), 64'd1);
        chk("stream_data_lit", 64'(data_out), 64'(i - 1));
      end
      step(1'b1, DW'(i), 1'b1, acc);
      if (!acc) chk("stream_accept", 64'(acc), 64'd1);
    end
    while (q.size() > 0) step(1'b0, '0, 1'b1, acc);

    // Fill with downstream stalled; fifth word must be held off
    tok = 1;
    for (int i = 0; i < 6 && tok <= 4; i++) begin
      step(1'b1, tok, 1'b0, acc);
      if (acc) tok++;
    end
    drive(1'b1, 32'd5, 1'b0);
    chk("fill_count_lit", 64'(count), 64'd4);
    chk("fill_pipe_ready_lit", 64'(pipe_ready), 64'd0);
    chk("fill_head_lit", 64'(data_out), 64'd1);
    step(1'b1, 32'd5, 1'b0, acc);
    chk("fill_fifth_held", 64'(acc), 64'd0);

    // Full push + pop
    drive(1'b1, 32'd5, 1'b1);
`ifdef PIPE_TAIL_REGISTERED_READY_EN
    chk("full_pp_ready_lit", 64'(pipe_ready), 64'd0);
`else
    chk("full_pp_ready_lit", 64'(pipe_ready), 64'd1);
`endif
    step(1'b1, 32'd5, 1'b1, acc);
    drive(1'b1, 32'd6, 1'b1);
`ifdef PIPE_TAIL_REGISTERED_READY_EN
    chk("full_pp_count_lit", 64'(count), 64'd3);
`else
    chk("full_pp_count_lit", 64'(count), 64'd4);
    chk("full_pp_head_lit", 64'(data_out), 64'd2);
`endif
    for (int i = 0; i < 6; i++) step(1'b1, DW'(6 + i), 1'b1, acc);

    // Top up to full, then drain
    tok = 32'h100;
    for (int i = 0; i < 10 && q.size() < DEPTH; i++) begin
      step(1'b1, tok, 1'b0, acc);
      if (acc) tok++;
    end
    chk("drain_start_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, acc);
    drive(1'b0, '0, 1'b1);
    chk("drain_valid_lit", 64'(valid), 64'd0);
    chk("drain_count_lit", 64'(count), 64'd0);

    // Random back-pressure over 1000 tokens, upstream holds until accepted
    accepted = 0; cycles = 0;
    tok = $urandom;
    pvalid = 1'b0;
    while (accepted < 1000 && cycles < 20000) begin
      logic pv;
      pv = pvalid ? 1'b1 : ($urandom_range(0, 9) < 8);
      step(pv, tok, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        accepted++;
        tok = $urandom;
        pvalid = 1'b0;
      end else begin
        pvalid = pv;
      end
      cycles++;
    end
    chk("random_budget", 64'(accepted), 64'd1000);
    while (q.size() > 0 && cycles < 21000) begin
      step(1'b0, '0, 1'b1, acc);
      cycles++;
    end

    // Asynchronous reset mid-stream with three words buffered
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h30 + i), 1'b0, acc);
    drive(1'b0, '0, 1'b0);
    chk("pre_reset_count", 64'(count), 64'd3);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_valid", 64'(valid), 64'd0);
    chk("async_reset_count", 64'(count), 64'd0);
    chk("async_reset_pipe_ready", 64'(pipe_ready), 64'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'hA5, 1'b0, acc);
    drive(1'b0, '0, 1'b0);
    chk("post_reset_valid", 64'(valid), 64'd1);
    chk("post_reset_data", 64'(data_out), 64'hA5);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_tail_fifo.md
# pipeline_tail_fifo

Elastic output stage placed directly downstream of the valid-tracking shift register of a fixed-latency pipelined operator. It captures the result data and tracked valid from the pipeline tail and presents them on a standard valid/ready handshake. It also generates the pipeline-advance enable that drives the shift register's ready input and the operator's clock enable. A `DEPTH`-entry FIFO absorbs downstream back-pressure so the operator pipeline stalls only when the FIFO is full.

## Interface
- `DATA_WIDTH`, default 32: width of the operator result.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserting low clears state immediately; release is synchronous to `clk`.
- `pvalid`  in  1  tracked valid from the pipeline tail (shift-register output).
- `data_in`  in  `DATA_WIDTH`  operator result, aligned with `pvalid`.
- `pipe_ready`  out  1  pipeline-advance enable, fed to the shift register's ready input and the operator enable.
- `valid`  out  1  output token valid.
- `data_out`  out  `DATA_WIDTH`  output token data.
- `nready`  in  1  downstream ready.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.

## Operation
- **Storage:** `DEPTH` × `DATA_WIDTH` array, write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy register `count`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
  - `full` = (`count` == `DEPTH`); `empty` = (`count` == 0).
- **Push:** `push` = `pvalid` & `pipe_ready`. On push, write `data_in` at `wr_ptr` and increment `wr_ptr`.
- **Pop:** `pop` = `valid` & `nready`. On pop, increment `rd_ptr`.
- **Count update:**
  - push only → +1
  - pop only → −1
  - both or neither → unchanged
- **Outputs:**
  - `valid` = !`empty`.
  - `data_out` = `mem[rd_ptr]`; don't-care while `valid` = 0.
- **No fall-through:** a word pushed into an empty FIFO is not presented in the same cycle.
- **Pipeline stall:** when `pipe_ready` = 0, `pvalid`/`data_in` are ignored. The upstream shift register and operator hold their state, so the tail token remains presented.
- **Integrity:** no token is lost or duplicated. Output order equals push order.

## Timing
- **Reset (`rst` low):**
  - `count` = 0, `wr_ptr` = `rd_ptr` = 0, `valid` = 0.
  - `pipe_ready` = 1 (FIFO empty).
  - Array contents are not reset.
- **Latency:** push at edge N → `valid` = 1 and `data_out` = that word after edge N (visible in cycle N+1).
- **Throughput:** one push and one pop per cycle sustained at any occupancy, including full (see Configuration).
- **Empty:** `pop` impossible. Push-only → `count` = 1.
- **Full:** `pipe_ready` depends on the macro. Push + pop at the same edge keeps `count` = `DEPTH` and advances both pointers.
- **Wrap-around:** after `DEPTH` pushes, `wr_ptr` returns to 0. Order is preserved across the wrap.
- **Reset mid-operation:** all buffered tokens are discarded, and `valid` drops asynchronously when `rst` goes low. The first push after release is the first token out.
- **Handshake rules:**
  - `valid` never deasserts without a pop, except on reset.
  - `data_out` is stable while `valid` = 1 and `nready` = 0.

## Configuration
- Macro: `PIPE_TAIL_REGISTERED_READY_EN`.
- **Undefined (default):** `pipe_ready` = !`full` | `nready`.
  - Combinational path from `nready` to `pipe_ready`.
  - Full-FIFO push+pop in one cycle is allowed.
- **Defined:** `pipe_ready` = !`full`, driven purely from registered `count` with no combinational path from `nready`.
  - When full, the pipeline stalls one cycle even if downstream pops; throughput loss only at `DEPTH` occupancy.

## Test plan
- **Reset:** hold `rst` low mid-stream with `count` = 3 → `valid` = 0, `count` = 0, `pipe_ready` = 1 immediately. After release, push 0xA5 → `data_out` = 0xA5 next cycle.
- **Streaming:** `nready` = 1, `pvalid` = 1 every cycle with data 1..100 → outputs 1..100 in order, one per cycle, `count` steady at 1.
- **Fill:** `nready` = 0, push 5 words with `DEPTH` = 4 → `count` = 4, `pipe_ready` = 0 after the 4th push. The 5th word is held at `pvalid`, not written.
- **Full push+pop:** full FIFO, `nready` = 1, `pvalid` = 1.
  - Macro off: `count` stays 4, `pipe_ready` = 1.
  - Macro on: `pipe_ready` = 0 that cycle, `count` → 3, then alternates.
- **Wrap:** random `nready` (50%) over 1000 tokens → scoreboard shows in-order, lossless, no duplicates. Pointers wrap at least 200 times.
- **Drain:** stop pushes with `count` = 4, `nready` = 1 → 4 pops on consecutive cycles, `valid` = 0 on the 5th cycle, `count` = 0.
